float8_div_seq: RTL and testbench



---
 rtl/float8_div_seq_if.sv | 22 ++
 rtl/float8_div_seq.sv | 154 +++++++++++++++
 tb/tb_float8_div_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/float8_div_seq_if.sv
// rtl/float8_div_seq_if.sv - operand/result handshake bundle for the float8 divider
interface float8_div_seq_if;
  logic       iValid;
  logic       oReady;
  logic [7:0] iNum1;
  logic [7:0] iNum2;
  logic       oValid;
  logic       iReady;
  logic [7:0] oNum;
  logic       oOverflow;
  logic       oDivZero;

  modport slave (
    input  iValid, iNum1, iNum2, iReady,
    output oReady, oValid, oNum, oOverflow, oDivZero
  );

  modport master (
    output iValid, iNum1, iNum2, iReady,
    input  oReady, oValid, oNum, oOverflow, oDivZero
  );
endinterface

// File: rtl/float8_div_seq.sv
// rtl/float8_div_seq.sv - sequential float8 divider (s|eee bias 4|ffff), restoring mantissa loop
module float8_div_seq (
  input  logic              iClk,
  input  logic              iRst_n,
  float8_div_seq_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, NORM, DIV, DONE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        n1_q, n1_d;
  logic [7:0]        n2_q, n2_d;
  logic [5:0]        r_q, r_d;
  logic [4:0]        b_q, b_d;
  logic signed [5:0] e_q, e_d;
  logic [2:0]        q_q, q_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [7:0]        num_q, num_d;
  logic              ovf_q, ovf_d;
  logic              dz_q, dz_d;
  logic              valid_q, valid_d;

  logic              sign;
  logic              z1, z2;
  logic [4:0]        a_mant, b_mant;
  logic signed [5:0] e_raw;
  logic              qbit;
  logic [4:0]        r_sub;
  logic [3:0]        q_new;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      n1_q    <= 8'h00;
      n2_q    <= 8'h00;
      r_q     <= 6'd0;
      b_q     <= 5'd0;
      e_q     <= 6'sd0;
      q_q     <= 3'd0;
      cnt_q   <= 3'd0;
      num_q   <= 8'h00;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n1_q    <= n1_d;
      n2_q    <= n2_d;
      r_q     <= r_d;
      b_q     <= b_d;
      e_q     <= e_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n1_d    = n1_q;
    n2_d    = n2_q;
    r_d     = r_q;
    b_d     = b_q;
    e_d     = e_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    valid_d = valid_q;

    sign   = n1_q[7] ^ n2_q[7];
    z1     = (n1_q[6:0] == 7'd0);
    z2     = (n2_q[6:0] == 7'd0);
    a_mant = {1'b1, n1_q[3:0]};
    b_mant = {1'b1, n2_q[3:0]};
    e_raw  = $signed({3'b000, n1_q[6:4]}) - $signed({3'b000, n2_q[6:4]}) + 6'sd4;
    // Remainder is always below 2*B, so after a successful subtract it fits in 5 bits
    qbit   = (r_q >= {1'b0, b_q});
    r_sub  = qbit ? (r_q[4:0] - b_q) : r_q[4:0];
    q_new  = {q_q, qbit};

    case (state_q)
      IDLE: begin
        if (bus.iValid) begin
          n1_d    = bus.iNum1;
          n2_d    = bus.iNum2;
          state_d = NORM;
        end
      end
      NORM: begin
        if (z2) begin
          dz_d    = 1'b1;
          num_d   = z1 ? 8'h00 : {sign, 7'h7F};
          valid_d = 1'b1;
          state_d = DONE;
        end else if (z1) begin
          num_d   = 8'h00;
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          b_d = b_mant;
          if (a_mant < b_mant) begin
            r_d = {a_mant, 1'b0};
            e_d = e_raw - 6'sd1;
          end else begin
            r_d = {1'b0, a_mant};
            e_d = e_raw;
          end
          q_d     = 3'd0;
          cnt_d   = 3'd0;
          state_d = DIV;
        end
      end
      DIV: begin
        r_d   = {r_sub, 1'b0};
        q_d   = q_new[2:0];
        cnt_d = cnt_q + 3'd1;
        // The leading quotient bit is always 1 after the pre-shift, so only the last 4 are kept
        if (cnt_q == 3'd4) begin
          valid_d = 1'b1;
          state_d = DONE;
          if (e_q > 6'sd7) begin
            num_d = {sign, 7'h7F};
            ovf_d = 1'b1;
          end else if (e_q < 6'sd0) begin
            num_d = 8'h00;
          end else begin
            num_d = {sign, e_q[2:0], q_new};
          end
        end
      end
      DONE: begin
        if (bus.iReady) begin
          valid_d = 1'b0;
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.oReady    = (state_q == IDLE);
  assign bus.oValid    = valid_q;
  assign bus.oNum      = num_q;
  assign bus.oOverflow = ovf_q;
  assign bus.oDivZero  = dz_q;

endmodule

// File: tb/tb_float8_div_seq.sv
// tb/tb_float8_div_seq.sv - scoreboard bench for float8_div_seq with arithmetic reference model
module tb_float8_div_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  float8_div_seq_if bus();

  float8_div_seq dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [7:0] num;
    logic       ovf;
    logic       dz;
    int         acc;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  bit         seen = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         handoffs = 0;
  int         accepts = 0;
  int         last_handoff = -10;
  bit         hold_mode = 0;
  int         hold_acc = 0;
  logic [9:0] last_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Quotient from the value definition: |q| = (m1/m2) * 2^(e1-e2), normalised to 1.ffff and truncated
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int acc);
    exp_t r;
    int m1, m2, e1, e2, ex, fr;
    logic s;
    r.acc = acc; r.num = 8'h00; r.ovf = 1'b0; r.dz = 1'b0; r.lat = 1;
    s = a[7] ^ b[7];
    if (b[6:0] == 7'd0) begin
      r.dz  = 1'b1;
      r.num = (a[6:0] != 7'd0) ? {s, 7'h7F} : 8'h00;
    end else if (a[6:0] != 7'd0) begin
      r.lat = 6;
      m1 = 16 + int'(a[3:0]);
      m2 = 16 + int'(b[3:0]);
      e1 = int'(a[6:4]);
      e2 = int'(b[6:4]);
      ex = e1 - e2 + 4;
      if (m1 >= m2) fr = (m1 * 16) / m2 - 16;
      else begin
        ex = ex - 1;
        fr = (m1 * 32) / m2 - 16;
      end
      if (ex > 7) begin
        r.num = {s, 7'h7F};
        r.ovf = 1'b1;
      end else if (ex >= 0) begin
        r.num = {s, 3'(ex), 4'(fr)};
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst_n && bus.oValid && bus.iReady) begin
      handoffs++;
      last_handoff = cyc;
    end
    if (rst_n && bus.iValid && bus.oReady) begin
      accepts++;
      sb.push_back(model(bus.iNum1, bus.iNum2, cyc));
      if (hold_mode) begin
        if (hold_acc > 0) check("hold_accept_gap", cyc - last_handoff, 1);
        hold_acc++;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (!bus.oValid) seen = 0;
    else if (!seen) begin
      seen = 1;
      last_res = {bus.oNum, bus.oOverflow, bus.oDivZero};
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: oNum=0x%0h with no pending operation", bus.oNum);
      end else begin
        cur = sb.pop_front();
        check("quotient", bus.oNum, cur.num);
        check("overflow", bus.oOverflow, cur.ovf);
        check("divzero", bus.oDivZero, cur.dz);
        check("latency", cyc - cur.acc - 1, cur.lat);
        check("ready_in_done", bus.oReady, 0);
      end
    end else begin
      check("held_num", bus.oNum, cur.num);
      check("held_ready", bus.oReady, 0);
    end
  end

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall);
    int t;
    bus.iNum1  = a;
    bus.iNum2  = b;
    bus.iValid = 1'b1;
    bus.iReady = (stall == 0);
    t = 0;
    while (!bus.oReady && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) check("accept_timeout", 1, 0);
    @(posedge clk); #1;
    bus.iValid = 1'b0;
    t = 0;
    while (!bus.oValid && t < 20) begin @(posedge clk); #1; t++; end
    if (t >= 20) check("result_timeout", 1, 0);
    repeat (stall) begin @(posedge clk); #1; end
    bus.iReady = 1'b1;
    @(posedge clk); #1;
  endtask

  logic [7:0] d_a   [11] = '{8'h43, 8'h38, 8'h20, 8'h40, 8'h7F, 8'hFF, 8'h01, 8'hC5, 8'h00, 8'h00, 8'h43};
  logic [7:0] d_b   [11] = '{8'h40, 8'hB8, 8'h50, 8'h3C, 8'h10, 8'h10, 8'h7F, 8'h00, 8'h00, 8'h33, 8'h40};
  logic [9:0] d_exp [11] = '{{8'h43,2'b00}, {8'hC0,2'b00}, {8'h10,2'b00}, {8'h42,2'b00},
                             {8'h7F,2'b10}, {8'hFF,2'b10}, {8'h00,2'b00}, {8'hFF,2'b01},
                             {8'h00,2'b01}, {8'h00,2'b00}, {8'h43,2'b00}};
  int         d_st  [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4};

  initial begin
    int t, a0, h0;
    bit saw;
    logic [7:0] ra, rb;
    bus.iValid = 1'b0;
    bus.iReady = 1'b1;
    bus.iNum1  = 8'h00;
    bus.iNum2  = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus.oValid, 0);
    check("rst_num", bus.oNum, 0);
    check("rst_ovf", bus.oOverflow, 0);
    check("rst_dz", bus.oDivZero, 0);
    check("rst_ready", bus.oReady, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      run_op(d_a[i], d_b[i], d_st[i]);
      check($sformatf("directed_%0d", i), last_res, d_exp[i]);
    end

    hold_mode = 1; hold_acc = 0;
    a0 = accepts; h0 = handoffs;
    bus.iNum1 = 8'h43; bus.iNum2 = 8'h40; bus.iReady = 1'b1; bus.iValid = 1'b1;
    t = 0;
    while (handoffs < h0 + 3 && t < 100) begin @(posedge clk); #1; t++; end
    bus.iValid = 1'b0;
    hold_mode = 0;
    if (t >= 100) check("hold_timeout", 1, 0);
    check("hold_accepts", accepts - a0, 3);

    bus.iNum1 = 8'h55; bus.iNum2 = 8'h31; bus.iValid = 1'b1;
    @(posedge clk); #1;
    bus.iValid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", bus.oValid, 0);
    check("midrst_num", bus.oNum, 0);
    check("midrst_ovf", bus.oOverflow, 0);
    check("midrst_dz", bus.oDivZero, 0);
    check("midrst_ready", bus.oReady, 1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    saw = 0;
    repeat (10) begin @(posedge clk); #1; if (bus.oValid) saw = 1; end
    check("no_valid_after_reset", saw, 0);
    run_op(8'h43, 8'h40, 0);
    check("post_reset_op", last_res, {8'h43, 2'b00});

    for (int i = 0; i < 150; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 7) == 0) ra[6:0] = 7'd0;
      if ($urandom_range(0, 7) == 0) rb[6:0] = 7'd0;
      run_op(ra, rb, int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
